// File: rtl/op_sequencer_pkg.sv
// Shared definitions for the operation sequencer: opcodes, instruction
// field layout and FSM state encoding.
package op_sequencer_pkg;

    // Opcodes; only HALT is decoded, the rest pass through to the ALU.
    localparam logic [5:0] OPC_HALT = 6'b000000;
    localparam logic [5:0] OPC_ADD  = 6'b000101;
    localparam logic [5:0] OPC_SUB  = 6'b001001;
    localparam logic [5:0] OPC_CUBE = 6'b010101;

    // Operand/destination address fields inside an instruction word.
    localparam int unsigned FIELD_W  = 7;
    localparam int unsigned SRCA_LSB = 14;
    localparam int unsigned SRCB_LSB = 7;
    localparam int unsigned DST_LSB  = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DEC,
        ST_LDA,
        ST_LDB,
        ST_ISSUE,
        ST_EXEC,
        ST_WB
    } state_t;

endpackage

// File: rtl/op_sequencer_watchdog.sv
// EXEC-phase watchdog: cleared on load, counts while enabled, flags expiry
// once TIMEOUT counted cycles have elapsed without an ALU completion.
module op_watchdog
    import op_sequencer_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic count,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    // Expiry is seen during the TIMEOUT-th counted cycle.
    always_comb begin
        expired = (cnt == CW'(TIMEOUT - 1));
    end

    // Cycle counter, held once expired so it never wraps.
    always_ff @(posedge clk) begin
        if (reset || load) begin
            cnt <= '0;
        end else if (count && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/op_sequencer.sv
// Operation sequencer: fetches instructions from a shared RAM, loads two
// operands, issues them to an external ALU and writes the result back.
// The host owns the RAM port only while the sequencer is idle.
module op_sequencer
    import op_sequencer_pkg::*;
#(
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 198,
    parameter int OP_W    = 6,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic              sel,
    input  logic              w,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] out,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_start,
    input  logic              alu_done,
    input  logic [DATA_W-1:0] alu_result
);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] pc;
    logic [OP_W-1:0]   instr_op;
    logic [ADDR_W-1:0] instr_b;
    logic [ADDR_W-1:0] instr_d;
    logic [DATA_W-1:0] opa, opb, res;
    logic              is_halt, pc_last;
    logic              wd_load, wd_count, wd_expired;

    assign is_halt   = (ram_rdata[DATA_W-1 -: OP_W] == OP_W'(OPC_HALT));
    assign pc_last   = (pc == '1);
    assign out       = ram_rdata;
    assign alu_op    = instr_op;
    assign alu_a     = opa;
    assign alu_b     = opb;

    op_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .load    (wd_load),
        .count   (wd_count),
        .expired (wd_expired)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:  if (start) state_nx = ST_FETCH;
            ST_FETCH: state_nx = ST_DEC;
            ST_DEC:   state_nx = is_halt ? ST_IDLE : ST_LDA;
            ST_LDA:   state_nx = ST_LDB;
            ST_LDB:   state_nx = ST_ISSUE;
            ST_ISSUE: state_nx = ST_EXEC;
            ST_EXEC: begin
                if (alu_done) begin
                    state_nx = ST_WB;
                end else if (wd_expired) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_WB:    state_nx = pc_last ? ST_IDLE : ST_FETCH;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // RAM port, ALU strobe and watchdog controls per state.
    always_comb begin
        busy      = (state != ST_IDLE);
        ram_addr  = pc;
        ram_we    = 1'b0;
        ram_wdata = '0;
        alu_start = 1'b0;
        wd_load   = 1'b0;
        wd_count  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                // A coincident start takes priority over the host access.
                if (sel && !start) begin
                    ram_addr  = addr;
                    ram_we    = w;
                    ram_wdata = data;
                end
            end
            ST_FETCH: ram_addr = pc;
            ST_DEC:   ram_addr = ADDR_W'(ram_rdata[SRCA_LSB +: FIELD_W]);
            ST_LDA:   ram_addr = instr_b;
            ST_LDB:   ram_addr = pc;
            ST_ISSUE: begin
                alu_start = 1'b1;
                wd_load   = 1'b1;
            end
            ST_EXEC:  wd_count = !alu_done;
            ST_WB: begin
                ram_we    = 1'b1;
                ram_addr  = instr_d;
                ram_wdata = res;
            end
            default: ;
        endcase
        // Reset aborts immediately: no write lands and no new ALU issue.
        if (reset) begin
            ram_we    = 1'b0;
            alu_start = 1'b0;
        end
    end

    // Program counter, instruction fields, operand/result and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= '0;
            instr_op <= '0;
            instr_b  <= '0;
            instr_d  <= '0;
            opa      <= '0;
            opb      <= '0;
            res      <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        pc   <= prog_addr;
                        done <= 1'b0;
                        err  <= 1'b0;
                    end
                end
                ST_DEC: begin
                    instr_op <= ram_rdata[DATA_W-1 -: OP_W];
                    instr_b  <= ADDR_W'(ram_rdata[SRCB_LSB +: FIELD_W]);
                    instr_d  <= ADDR_W'(ram_rdata[DST_LSB +: FIELD_W]);
                    if (is_halt) done <= 1'b1;
                end
                ST_LDA: opa <= ram_rdata;
                ST_LDB: opb <= ram_rdata;
                ST_EXEC: begin
                    if (alu_done) begin
                        res <= alu_result;
                    end else if (wd_expired) begin
                        err  <= 1'b1;
                        done <= 1'b0;
                    end
                end
                ST_WB: begin
                    if (pc_last) begin
                        err <= 1'b1;
                    end else begin
                        pc <= pc + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_op_sequencer.sv
// Self-checking bench for op_sequencer: behavioural RAM and ALU models,
// scoreboard queues for ALU issues and write-backs.
module tb_op_sequencer;

    localparam int AW = 7;
    localparam int DW = 198;
    localparam int OW = 6;
    localparam int TO = 255;

    localparam logic [OW-1:0] T_HALT = 6'b000000;
    localparam logic [OW-1:0] T_ADD  = 6'b000101;
    localparam logic [OW-1:0] T_SUB  = 6'b001001;
    localparam logic [OW-1:0] T_CUBE = 6'b010101;
    localparam logic [OW-1:0] T_UNK  = 6'b111111;

    logic          clk, reset, start, sel, w;
    logic [AW-1:0] prog_addr, addr, ram_addr;
    logic [DW-1:0] data, out, ram_wdata, ram_rdata, alu_a, alu_b, alu_result;
    logic          busy, done, err, ram_we, alu_start, alu_done;
    logic [OW-1:0] alu_op;

    logic          alu_hang;
    logic [DW-1:0] mem [128] = '{default: '0};

    int n_chk = 0;
    int n_err = 0;
    int n_start = 0;

    typedef struct { logic [OW-1:0] op; logic [DW-1:0] a; logic [DW-1:0] b; } iss_t;
    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wb_t;
    iss_t iss_q[$];
    wb_t  wb_q[$];

    op_sequencer #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .OP_W    (OW),
        .TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .prog_addr  (prog_addr),
        .sel        (sel),
        .w          (w),
        .addr       (addr),
        .data       (data),
        .out        (out),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_start  (alu_start),
        .alu_done   (alu_done),
        .alu_result (alu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] alu_f(input logic [OW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (op)
            T_ADD:   return a + b;
            T_SUB:   return a - b;
            T_CUBE:  return a * a * a;
            default: return a ^ {b[DW-2:0], 1'b0};
        endcase
    endfunction

    function automatic logic [DW-1:0] mk(input logic [OW-1:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] d);
        logic [DW-1:0] x;
        x = '0;
        x[100] = 1'b1;              // ignored bit, must not disturb decoding
        x[DW-1 -: OW] = op;
        x[20:14] = a;
        x[13:7]  = b;
        x[6:0]   = d;
        return x;
    endfunction

    // Single-port RAM, one-cycle read latency.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    // ALU answering one cycle after alu_start unless hung.
    always @(posedge clk) begin
        alu_done <= 1'b0;
        if (alu_start && !alu_hang) begin
            alu_done   <= 1'b1;
            alu_result <= alu_f(alu_op, alu_a, alu_b);
        end
    end

    // Scoreboard: every ALU issue and every write-back while busy is expected.
    always @(negedge clk) begin : mon
        iss_t ie;
        wb_t  we;
        if (alu_start) begin
            n_start++;
            if (iss_q.size() == 0) begin
                check("alu_start_unexpected", 1'b1, 1'b0);
            end else begin
                ie = iss_q.pop_front();
                check("alu_op", alu_op, ie.op);
                check("alu_a", alu_a, ie.a);
                check("alu_b", alu_b, ie.b);
            end
        end
        if (busy && ram_we) begin
            if (wb_q.size() == 0) begin
                check("wb_unexpected", 1'b1, 1'b0);
            end else begin
                we = wb_q.pop_front();
                check("wb_addr", ram_addr, we.a);
                check("wb_data", ram_wdata, we.d);
            end
        end
    end

    task automatic host_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        sel = 1'b1; w = 1'b1; addr = a; data = d;
        @(negedge clk);
        sel = 1'b0; w = 1'b0;
    endtask

    task automatic host_rd(input logic [AW-1:0] a, output logic [DW-1:0] d);
        @(negedge clk);
        sel = 1'b1; w = 1'b0; addr = a;
        @(negedge clk);
        d = out;
        sel = 1'b0;
    endtask

    // Pulse start (optionally with a colliding host write) and count edges
    // from the one that samples start until busy drops.
    task automatic run(input logic [AW-1:0] pa, input logic hsel, input logic [AW-1:0] ha,
                       input logic [DW-1:0] hd, input int limit, output int cyc);
        @(negedge clk);
        start = 1'b1; prog_addr = pa;
        sel = hsel; w = hsel; addr = ha; data = hd;
        @(posedge clk);
        #1;
        start = 1'b0; sel = 1'b0; w = 1'b0;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (busy && cyc < limit);
        if (busy) check("run_timeout", busy, 1'b0);
    endtask

    task automatic push_prog_a(input logic [DW-1:0] r2, input logic [DW-1:0] r3);
        iss_q.push_back('{T_SUB, 198'd100, 198'd7});
        wb_q.push_back('{7'd22, 198'd93});
        iss_q.push_back('{T_CUBE, 198'd93, 198'd7});
        wb_q.push_back('{7'd23, r2});
        iss_q.push_back('{T_UNK, r2, 198'd93});
        wb_q.push_back('{7'd23, r3});
    endtask

    initial begin : timeout_guard
        #300000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin : main
        int            cyc, s0;
        logic [DW-1:0] rd, r2, r3;

        reset = 1'b1; start = 1'b0; sel = 1'b0; w = 1'b0; alu_hang = 1'b0;
        prog_addr = '0; addr = '0; data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_alu_start", alu_start, 1'b0);
        check("rst_ram_we", ram_we, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Basic ADD then HALT.
        host_wr(7'd0, mk(T_ADD, 7'd3, 7'd4, 7'd5));
        host_wr(7'd1, mk(T_HALT, 7'd0, 7'd0, 7'd0));
        host_wr(7'd3, 198'd1);
        host_wr(7'd4, 198'd1);
        iss_q.push_back('{T_ADD, 198'd1, 198'd1});
        wb_q.push_back('{7'd5, 198'd2});
        s0 = n_start;
        run(7'd0, 1'b0, '0, '0, 200, cyc);
        check("add_cycles", cyc, 9);
        check("add_done", done, 1'b1);
        check("add_err", err, 1'b0);
        check("add_nstart", n_start - s0, 1);
        host_rd(7'd5, rd);
        check("add_word5", rd, 198'd2);

        // Three-instruction program with dependencies, unknown opcode, src==dst.
        r2 = alu_f(T_CUBE, 198'd93, 198'd7);
        r3 = alu_f(T_UNK, r2, 198'd93);
        host_wr(7'd20, 198'd100);
        host_wr(7'd21, 198'd7);
        host_wr(7'd10, mk(T_SUB, 7'd20, 7'd21, 7'd22));
        host_wr(7'd11, mk(T_CUBE, 7'd22, 7'd21, 7'd23));
        host_wr(7'd12, mk(T_UNK, 7'd23, 7'd22, 7'd23));
        host_wr(7'd13, mk(T_HALT, 7'd1, 7'd2, 7'd3));
        push_prog_a(r2, r3);
        run(7'd10, 1'b0, '0, '0, 200, cyc);
        check("prog3_cycles", cyc, 23);
        check("prog3_done", done, 1'b1);
        check("prog3_err", err, 1'b0);
        host_rd(7'd23, rd);
        check("prog3_word23", rd, r3);

        // Host write and start pulse while busy must be ignored.
        push_prog_a(r2, r3);
        fork
            run(7'd10, 1'b0, '0, '0, 200, cyc);
            begin
                repeat (8) @(negedge clk);
                sel = 1'b1; w = 1'b1; addr = 7'd10; data = 198'hDEAD;
                start = 1'b1; prog_addr = 7'd0;
                @(negedge clk);
                sel = 1'b0; w = 1'b0; start = 1'b0;
            end
        join
        check("busy_run_cycles", cyc, 23);
        check("busy_run_done", done, 1'b1);
        host_rd(7'd10, rd);
        check("busy_word10", rd, mk(T_SUB, 7'd20, 7'd21, 7'd22));

        // Watchdog: ALU never answers.
        alu_hang = 1'b1;
        host_wr(7'd30, mk(T_ADD, 7'd20, 7'd21, 7'd40));
        host_wr(7'd31, mk(T_HALT, 7'd0, 7'd0, 7'd0));
        iss_q.push_back('{T_ADD, 198'd100, 198'd7});
        @(negedge clk);
        start = 1'b1; prog_addr = 7'd30;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!alu_start && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("wd_issue_seen", alu_start, 1'b1);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 100) check("wd_hold_a", alu_a, 198'd100);
        end while (busy && cyc < 400);
        check("wd_cycles", cyc, 256);
        check("wd_err", err, 1'b1);
        check("wd_done", done, 1'b0);
        check("wd_busy", busy, 1'b0);
        host_rd(7'd40, rd);
        check("wd_word40", rd, '0);

        // Last address: write-back lands, then error halt.
        alu_hang = 1'b0;
        host_wr(7'd127, mk(T_ADD, 7'd20, 7'd21, 7'd60));
        iss_q.push_back('{T_ADD, 198'd100, 198'd7});
        wb_q.push_back('{7'd60, 198'd107});
        run(7'd127, 1'b0, '0, '0, 200, cyc);
        check("pcend_cycles", cyc, 7);
        check("pcend_err", err, 1'b1);
        check("pcend_done", done, 1'b0);
        host_rd(7'd60, rd);
        check("pcend_word60", rd, 198'd107);

        // Reset during EXEC aborts without write-back.
        alu_hang = 1'b1;
        host_wr(7'd70, mk(T_ADD, 7'd20, 7'd21, 7'd61));
        host_wr(7'd71, mk(T_HALT, 7'd0, 7'd0, 7'd0));
        iss_q.push_back('{T_ADD, 198'd100, 198'd7});
        @(negedge clk);
        start = 1'b1; prog_addr = 7'd70;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!alu_start && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("rx_issue_seen", alu_start, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rx_busy", busy, 1'b0);
        check("rx_done", done, 1'b0);
        check("rx_err", err, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        host_rd(7'd61, rd);
        check("rx_word61", rd, '0);

        // Fresh start after reset, with a colliding host write that must drop.
        alu_hang = 1'b0;
        iss_q.push_back('{T_ADD, 198'd100, 198'd7});
        wb_q.push_back('{7'd61, 198'd107});
        run(7'd70, 1'b1, 7'd90, 198'hBEEF, 200, cyc);
        check("rx2_cycles", cyc, 9);
        check("rx2_done", done, 1'b1);
        check("rx2_err", err, 1'b0);
        host_rd(7'd61, rd);
        check("rx2_word61", rd, 198'd107);
        host_rd(7'd90, rd);
        check("collide_word90", rd, '0);

        check("iss_q_empty", iss_q.size(), 0);
        check("wb_q_empty", wb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
